divider_rr_arbiter: RTL and testbench

- Shares one sequential restoring divider (Start/Ready/Error handshake; quotient width L_divn, remainder width L_divr) among N_REQ requesters.
- Grants requesters round-robin and latches the winner's operands.
- Resolves trivial cases locally: divisor 0 and dividend 0.
- Drives the divider Start pulse, waits for completion and returns quotient/remainder/error with a one-cycle ack.
- Recovers the divider from its sticky error state, or from a hang, with a divider-reset pulse.

---
 rtl/divider_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_divider_rr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_rr_arbiter.sv
// rtl/divider_rr_arbiter.sv - round-robin front end sharing one sequential divider
// Trivial operands are answered locally; divider errors and hangs end in a div_reset pulse.
module divider_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int L_divn  = 8,
  parameter int L_divr  = 4,
  parameter int L_ptr   = 2,
  parameter int TIMEOUT = 63,
  parameter int L_tmr   = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*L_divn-1:0]   dividend_in,
  input  logic [N_REQ*L_divr-1:0]   divisor_in,
  output logic [N_REQ-1:0]          ack,
  output logic [L_divn-1:0]         quotient_out,
  output logic [L_divr-1:0]         remainder_out,
  output logic                      err_out,
  output logic                      busy,
  output logic                      div_start,
  output logic [L_divn-1:0]         div_word1,
  output logic [L_divr-1:0]         div_word2,
  output logic                      div_reset,
  input  logic                      div_ready,
  input  logic                      div_error,
  input  logic [L_divn-1:0]         div_quotient,
  input  logic [L_divr-1:0]         div_remainder
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RECOV, DONE} state_t;

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t            state;
  logic [L_ptr-1:0]  ptr;
  logic [L_ptr-1:0]  sel;
  logic [L_tmr-1:0]  timer;
  logic [L_divn-1:0] op_dividend;
  logic [L_divr-1:0] op_divisor;

  logic [L_divn-1:0] dividend_slot [N_REQ];
  logic [L_divr-1:0] divisor_slot  [N_REQ];
  logic [L_ptr-1:0]  win;
  logic              found;
  logic [31:0]       scan;
  logic [L_divn-1:0] win_dividend;
  logic [L_divr-1:0] win_divisor;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign dividend_slot[g] = dividend_in[g*L_divn +: L_divn];
    assign divisor_slot[g]  = divisor_in[g*L_divr +: L_divr];
  end

  // First asserted request at or after ptr, wrapping at N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    scan  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = 32'((int'(ptr) + i) % N_REQ);
      if (!found && req[scan[L_ptr-1:0]]) begin
        found = 1'b1;
        win   = scan[L_ptr-1:0];
      end
    end
  end

  assign win_dividend = dividend_slot[win];
  assign win_divisor  = divisor_slot[win];

  assign div_word1 = op_dividend;
  assign div_word2 = op_divisor;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      sel           <= '0;
      timer         <= '0;
      op_dividend   <= '0;
      op_divisor    <= '0;
      ack           <= '0;
      quotient_out  <= '0;
      remainder_out <= '0;
      err_out       <= 1'b0;
      busy          <= 1'b0;
      div_start     <= 1'b0;
      div_reset     <= 1'b0;
    end else begin
      ack       <= '0;
      div_start <= 1'b0;
      div_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (found && div_ready) begin
            sel         <= win;
            op_dividend <= win_dividend;
            op_divisor  <= win_divisor;
            busy        <= 1'b1;
            if (win_divisor == '0) begin
              quotient_out  <= '0;
              remainder_out <= '0;
              err_out       <= 1'b1;
              ack           <= ONE_HOT0 << win;
              state         <= DONE;
            end else if (win_dividend == '0) begin
              quotient_out  <= '0;
              remainder_out <= '0;
              err_out       <= 1'b0;
              ack           <= ONE_HOT0 << win;
              state         <= DONE;
            end else begin
              div_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // timer == 0 marks the first WAIT cycle, where Ready may still be stale.
          if (div_error) begin
            div_reset <= 1'b1;
            state     <= RECOV;
          end else if (div_ready && timer != '0) begin
            quotient_out  <= div_quotient;
            remainder_out <= div_remainder;
            err_out       <= 1'b0;
            ack           <= ONE_HOT0 << sel;
            state         <= DONE;
          end else if (timer == L_tmr'(TIMEOUT)) begin
            div_reset <= 1'b1;
            state     <= RECOV;
          end
        end
        RECOV: begin
          quotient_out  <= '0;
          remainder_out <= '0;
          err_out       <= 1'b1;
          ack           <= ONE_HOT0 << sel;
          state         <= DONE;
        end
        DONE: begin
          ptr   <= (sel == L_ptr'(N_REQ - 1)) ? '0 : sel + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_rr_arbiter.sv
// tb/tb_divider_rr_arbiter.sv - directed vector bench for divider_rr_arbiter
// A behavioural divider model supports normal, hanging and erroring modes.
module tb_divider_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] dividend_in;
  logic [15:0] divisor_in;
  logic [3:0]  ack;
  logic [7:0]  quotient_out;
  logic [3:0]  remainder_out;
  logic        err_out;
  logic        busy;
  logic        div_start;
  logic [7:0]  div_word1;
  logic [3:0]  div_word2;
  logic        div_reset;
  logic        div_ready;
  logic        div_error;
  logic [7:0]  div_quotient;
  logic [3:0]  div_remainder;

  int checks = 0;
  int failures = 0;
  int mode = 0;

  logic [7:0] m_a;
  logic [3:0] m_b;
  int         m_cnt;

  always #5 clock = ~clock;

  divider_rr_arbiter dut (
    .clock(clock), .reset(reset), .req(req),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .ack(ack), .quotient_out(quotient_out), .remainder_out(remainder_out),
    .err_out(err_out), .busy(busy), .div_start(div_start),
    .div_word1(div_word1), .div_word2(div_word2), .div_reset(div_reset),
    .div_ready(div_ready), .div_error(div_error),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // mode 0: result after 3 busy cycles, 1: Ready never returns, 2: Error raised
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      div_ready <= 1'b1; div_error <= 1'b0; m_cnt <= 0;
      div_quotient <= '0; div_remainder <= '0; m_a <= '0; m_b <= '0;
    end else if (div_reset) begin
      div_ready <= 1'b1; div_error <= 1'b0; m_cnt <= 0;
    end else if (div_start) begin
      div_ready <= 1'b0;
      m_a <= div_word1;
      m_b <= div_word2;
      if (mode == 2) div_error <= 1'b1;
      m_cnt <= (mode == 0) ? 3 : 0;
    end else if (m_cnt == 1) begin
      div_ready     <= 1'b1;
      div_quotient  <= m_a / 8'(m_b);
      div_remainder <= 4'(m_a % 8'(m_b));
      m_cnt <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int slot, input logic [7:0] d, input logic [3:0] v);
    dividend_in[slot*8 +: 8] = d;
    divisor_in[slot*4 +: 4]  = v;
  endtask

  task automatic serve(input logic [3:0] r, output logic [3:0] a, output int starts,
                       output int gap, output int resets);
    int t_s = -1;
    int t_r = -1;
    logic seen = 1'b0;
    req = r; starts = 0; resets = 0; a = '0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clock);
      if (div_start) begin starts++; t_s = t; end
      if (div_reset) begin resets++; t_r = t; end
      if (ack != 4'b0) begin seen = 1'b1; a = ack; end
    end
    check("serve_ack_timeout", 64'(seen), 64'd1);
    req = '0;
    gap = (t_s >= 0 && t_r >= 0) ? t_r - t_s : -1;
  endtask

  task automatic next_ack(output logic [3:0] a);
    logic seen = 1'b0;
    a = '0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clock);
      if (ack != 4'b0) begin seen = 1'b1; a = ack; end
    end
    check("next_ack_timeout", 64'(seen), 64'd1);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [7:0] d;
    logic [3:0] v;
    int         mode;
    logic [3:0] ack;
    logic [7:0] q;
    logic [3:0] r;
    logic       err;
    int         starts;
    int         gap;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [3:0] a;
    logic [3:0] rr_exp [5];
    logic       ack_during_reset;
    logic       start_seen;
    int         starts, gap, resets, slot;

    vecs[0] = '{4'b0001, 8'd100, 4'd7,  0, 4'b0001, 8'd14, 4'd2, 1'b0, 1, 0};
    vecs[1] = '{4'b0100, 8'd55,  4'd0,  0, 4'b0100, 8'd0,  4'd0, 1'b1, 0, 0};
    vecs[2] = '{4'b0001, 8'd0,   4'd5,  0, 4'b0001, 8'd0,  4'd0, 1'b0, 0, 0};
    vecs[3] = '{4'b0010, 8'd255, 4'd15, 0, 4'b0010, 8'd17, 4'd0, 1'b0, 1, 0};
    vecs[4] = '{4'b1000, 8'd200, 4'd9,  0, 4'b1000, 8'd22, 4'd2, 1'b0, 1, 0};
    vecs[5] = '{4'b0100, 8'd7,   4'd9,  0, 4'b0100, 8'd0,  4'd7, 1'b0, 1, 0};
    vecs[6] = '{4'b0010, 8'd50,  4'd3,  1, 4'b0010, 8'd0,  4'd0, 1'b1, 1, 65};
    vecs[7] = '{4'b0001, 8'd9,   4'd2,  2, 4'b0001, 8'd0,  4'd0, 1'b1, 1, 2};
    vecs[8] = '{4'b1000, 8'd0,   4'd0,  0, 4'b1000, 8'd0,  4'd0, 1'b1, 0, 0};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset = 1'b1; req = '0; dividend_in = '0; divisor_in = '0;
    repeat (2) @(negedge clock);
    check("rst_outputs", 64'({ack, busy, div_start, div_reset, quotient_out, remainder_out, err_out}), 64'd0);
    check("rst_words", 64'({div_word1, div_word2}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Round robin from ptr = 0, all locally answered (divisor 0).
    dividend_in = {8'd4, 8'd3, 8'd2, 8'd1};
    divisor_in  = '0;
    req = 4'b1010;
    next_ack(a);
    check("rr_pair_first", 64'(a), 64'b0010);
    check("rr_pair_err", 64'(err_out), 64'd1);
    req = 4'b1000;
    next_ack(a);
    check("rr_pair_second", 64'(a), 64'b1000);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      next_ack(a);
      check($sformatf("rr_all_%0d", k), 64'(a), 64'(rr_exp[k]));
    end
    req = '0;
    @(negedge clock);

    for (int i = 0; i < 9; i++) begin
      mode = vecs[i].mode;
      dividend_in = 32'hFFFF_FFFF;
      divisor_in  = 16'hFFFF;
      slot = 0;
      for (int b = 0; b < 4; b++) if (vecs[i].req[b]) slot = b;
      set_ops(slot, vecs[i].d, vecs[i].v);
      serve(vecs[i].req, a, starts, gap, resets);
      check($sformatf("v%0d_ack", i), 64'(a), 64'(vecs[i].ack));
      check($sformatf("v%0d_q", i), 64'(quotient_out), 64'(vecs[i].q));
      check($sformatf("v%0d_r", i), 64'(remainder_out), 64'(vecs[i].r));
      check($sformatf("v%0d_err", i), 64'(err_out), 64'(vecs[i].err));
      check($sformatf("v%0d_starts", i), 64'(starts), 64'(vecs[i].starts));
      check($sformatf("v%0d_resets", i), 64'(resets), 64'(vecs[i].gap != 0));
      if (vecs[i].gap != 0)
        check($sformatf("v%0d_recov_gap", i), 64'(gap), 64'(vecs[i].gap));
      @(negedge clock);
      check($sformatf("v%0d_busy_after", i), 64'(busy), 64'd0);
    end

    // Leave ptr at 2, then reset in the middle of a hung WAIT.
    mode = 0;
    divisor_in = '0;
    serve(4'b0010, a, starts, gap, resets);
    check("pre_reset_ack", 64'(a), 64'b0010);
    @(negedge clock);
    mode = 1;
    set_ops(2, 8'd50, 4'd3);
    req = 4'b0100;
    start_seen = 1'b0;
    for (int t = 0; t < 20 && !start_seen; t++) begin
      @(negedge clock);
      if (div_start) start_seen = 1'b1;
    end
    check("midwait_start_seen", 64'(start_seen), 64'd1);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midwait_rst_outputs", 64'({ack, busy, div_start, div_reset, quotient_out, remainder_out, err_out}), 64'd0);
    check("midwait_rst_words", 64'({div_word1, div_word2}), 64'd0);
    ack_during_reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (ack != 4'b0) ack_during_reset = 1'b1;
    end
    check("midwait_no_ack", 64'(ack_during_reset), 64'd0);
    mode = 0;
    set_ops(1, 8'd9, 4'd0);
    req = 4'b0110;
    reset = 1'b0;
    next_ack(a);
    check("after_reset_ptr0", 64'(a), 64'b0010);
    req = '0;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
